// File: rtl/dm_sba_wb_pkg.sv
// Shared types and sizing helpers for the debug-module SBA to Wishbone responder.
package dm_sba_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DefaultTimeoutCycles = 255;

    // Timeout counter width: wide enough to hold TimeoutCycles, never narrower than 1 bit.
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

    localparam int DefaultCntWidth = cnt_width(DefaultTimeoutCycles);

endpackage

// File: rtl/dm_sba_wb_responder.sv
// Replays one DM system-bus-access request as a single-beat Wishbone cycle
// and returns one r_valid completion (data or error) per grant.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for req_i; grant and capture the command
// BUS     | Wishbone cycle open; wait for ack, err or timeout
// RESP    | one-cycle r_valid pulse, then back to IDLE
module dm_sba_wb_responder
    import dm_sba_wb_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = DefaultTimeoutCycles
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic [AddrWidth-1:0]   add_i,
    input  logic                   we_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic                   gnt_o,
    output logic                   r_valid_o,
    output logic [DataWidth-1:0]   r_rdata_o,
    output logic                   r_err_o,
    output logic [AddrWidth-1:0]   wb_adr_o,
    output logic [DataWidth-1:0]   wb_dat_o,
    output logic [DataWidth/8-1:0] wb_sel_o,
    output logic                   wb_we_o,
    output logic                   wb_cyc_o,
    input  logic [DataWidth-1:0]   wb_dat_i,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i
);

    localparam int CntW = cnt_width(TimeoutCycles);
    localparam logic TimeoutEn = (TimeoutCycles != 0);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutEn ? TimeoutCycles - 1 : 0);
    localparam logic [AddrWidth-1:0] WordMask = ~AddrWidth'(3);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q;
    logic                   timeout_hit;
    logic                   done;
    logic                   done_err;
    logic [DataWidth-1:0]   done_rdata;

    assign timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);

    always_comb begin
        state_d    = state_q;
        done       = 1'b0;
        done_err   = 1'b0;
        done_rdata = '0;
        gnt_o      = 1'b0;
        wb_cyc_o   = 1'b0;
        r_valid_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_o = req_i;
                if (req_i) state_d = ST_BUS;
            end
            ST_BUS: begin
                wb_cyc_o = 1'b1;
                // ack wins over err, err wins over timeout
                if (wb_ack_i) begin
                    done       = 1'b1;
                    done_rdata = wb_we_o ? '0 : wb_dat_i;
                end else if (wb_err_i || timeout_hit) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
                if (done) state_d = ST_RESP;
            end
            ST_RESP: begin
                r_valid_o = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_we_o   <= 1'b0;
            r_rdata_o <= '0;
            r_err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == ST_BUS) ? cnt_q + CntW'(1) : '0;
            if (state_q == ST_IDLE && req_i) begin
                wb_adr_o <= add_i & WordMask;
                wb_dat_o <= wdata_i;
                wb_sel_o <= be_i;
                wb_we_o  <= we_i;
            end
            if (done) begin
                r_rdata_o <= done_rdata;
                r_err_o   <= done_err;
            end
        end
    end

endmodule

// File: tb/tb_dm_sba_wb_responder.sv
// Directed bench for dm_sba_wb_responder: cycle-indexed transaction model checked
// every cycle, plus literal expectations for each scenario.
module tb_dm_sba_wb_responder;

    localparam int TO = 8;

    logic        clk_i, rst_i, req_i, we_i;
    logic [31:0] add_i, wdata_i;
    logic [3:0]  be_i;
    logic        gnt_o, r_valid_o, r_err_o, wb_we_o, wb_cyc_o;
    logic [31:0] r_rdata_o, wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;

    dm_sba_wb_responder #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .we_i(we_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_rdata_o(r_rdata_o), .r_err_o(r_err_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave: s_mode 0 = never answer, 1 = ack on BUS cycle s_n, 2 = err on BUS cycle s_n
    int          s_mode = 0;
    int          s_n = 1;
    logic [31:0] s_rdata = '0;
    logic        s_stray = 1'b0;
    int          bn = 0;

    always @(posedge clk_i) begin
        #1;
        if (wb_cyc_o) bn++;
        else bn = 0;
        wb_ack_i = (wb_cyc_o && s_mode == 1 && bn == s_n) || s_stray;
        wb_err_i = wb_cyc_o && s_mode == 2 && bn == s_n;
        wb_dat_i = s_rdata;
    end

    // Transaction model indexed by cycle number.
    int          cyc_idx = 0;
    int          g_at = -1;
    int          done_at = -1;
    logic [31:0] m_adr = '0, m_dat = '0, m_rdata = '0;
    logic [3:0]  m_sel = '0;
    logic        m_we = 1'b0, m_err = 1'b0;
    int          cyc_run = 0, last_cyc_len = 0, rv_total = 0, gnt_total = 0;

    always @(negedge clk_i) begin
        logic e_gnt, e_cyc, e_rv;
        int   k;
        cyc_idx++;
        if (rst_i) begin
            g_at = -1; done_at = -1;
            m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0;
            m_rdata = '0; m_err = 1'b0; cyc_run = 0;
        end
        e_gnt = (g_at < 0) && req_i;
        e_cyc = (g_at >= 0) && (done_at < 0) && (cyc_idx > g_at);
        e_rv  = (done_at >= 0) && (cyc_idx == done_at + 1);
        chk("gnt", 64'(gnt_o), 64'(e_gnt));
        chk("cyc", 64'(wb_cyc_o), 64'(e_cyc));
        chk("r_valid", 64'(r_valid_o), 64'(e_rv));
        chk("wb_adr", 64'(wb_adr_o), 64'(m_adr));
        chk("wb_dat", 64'(wb_dat_o), 64'(m_dat));
        chk("wb_sel", 64'(wb_sel_o), 64'(m_sel));
        chk("wb_we", 64'(wb_we_o), 64'(m_we));
        chk("r_rdata", 64'(r_rdata_o), 64'(m_rdata));
        chk("r_err", 64'(r_err_o), 64'(m_err));

        if (wb_cyc_o) cyc_run++;
        if (gnt_o) gnt_total++;
        if (r_valid_o) begin
            last_cyc_len = cyc_run;
            cyc_run = 0;
            rv_total++;
        end

        if (!rst_i) begin
            if (e_rv) begin g_at = -1; done_at = -1; end
            if (e_cyc) begin
                k = cyc_idx - g_at;
                if (wb_ack_i) begin
                    done_at = cyc_idx; m_err = 1'b0;
                    m_rdata = m_we ? 32'h0 : wb_dat_i;
                end else if (wb_err_i || k == TO) begin
                    done_at = cyc_idx; m_err = 1'b1; m_rdata = 32'h0;
                end
            end
            if (e_gnt) begin
                g_at = cyc_idx;
                m_adr = add_i & 32'hFFFF_FFFC;
                m_dat = wdata_i; m_sel = be_i; m_we = we_i;
            end
        end
    end

    int last_lat = 0;

    task automatic wait_gnt();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (gnt_o) begin ok = 1; break; end
        end
        if (!ok) chk("gnt_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic wait_rv();
        bit ok = 0;
        last_lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            last_lat++;
            if (r_valid_o) begin ok = 1; break; end
        end
        if (!ok) chk("rvalid_wait_expired", 64'd0, 64'd1);
    endtask

    // Entered and left at posedge+1.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input int mode, input int n);
        s_mode = mode; s_n = n;
        we_i = w; add_i = a; wdata_i = d; be_i = b; req_i = 1'b1;
        wait_gnt();
        @(posedge clk_i); #1 req_i = 1'b0;
        wait_rv();
        @(posedge clk_i); #1;
    endtask

    initial begin
        int rv0, gt0;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; add_i = '0; wdata_i = '0; be_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;

        s_rdata = 32'hDEADBEEF;
        txn(1'b0, 32'h2004, 32'h0, 4'hF, 1, 1);
        chk("rd1_rdata", 64'(r_rdata_o), 64'hDEADBEEF);
        chk("rd1_err", 64'(r_err_o), 64'd0);
        chk("rd1_adr", 64'(wb_adr_o), 64'h2004);
        chk("rd1_cyc_len", 64'(last_cyc_len), 64'd1);
        chk("rd1_latency", 64'(last_lat), 64'd2);

        s_rdata = 32'hFFFFFFFF;
        txn(1'b1, 32'h3001, 32'h000000AA, 4'h2, 1, 4);
        chk("wr_adr", 64'(wb_adr_o), 64'h3000);
        chk("wr_sel", 64'(wb_sel_o), 64'h2);
        chk("wr_we", 64'(wb_we_o), 64'd1);
        chk("wr_dat", 64'(wb_dat_o), 64'hAA);
        chk("wr_cyc_len", 64'(last_cyc_len), 64'd4);
        chk("wr_rdata", 64'(r_rdata_o), 64'd0);
        chk("wr_err", 64'(r_err_o), 64'd0);

        s_stray = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 s_stray = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 chk("stray_ack_rv_count", 64'(rv_total), 64'd2);

        s_rdata = 32'h5555AAAA;
        txn(1'b0, 32'h4008, 32'h0, 4'hF, 2, 2);
        chk("err_err", 64'(r_err_o), 64'd1);
        chk("err_rdata", 64'(r_rdata_o), 64'd0);
        chk("err_cyc_len", 64'(last_cyc_len), 64'd2);

        txn(1'b0, 32'h5000, 32'h0, 4'hF, 0, 0);
        chk("to_err", 64'(r_err_o), 64'd1);
        chk("to_rdata", 64'(r_rdata_o), 64'd0);
        chk("to_cyc_len", 64'(last_cyc_len), 64'd8);
        chk("to_latency", 64'(last_lat), 64'd9);

        // Request arriving in the cycle right after r_valid is granted immediately.
        s_mode = 1; s_n = 1; s_rdata = 32'h0BADF00D;
        we_i = 1'b0; add_i = 32'h6006; be_i = 4'hF; req_i = 1'b1;
        @(negedge clk_i);
        chk("to_next_gnt", 64'(gnt_o), 64'd1);
        @(posedge clk_i); #1 req_i = 1'b0;
        wait_rv();
        @(posedge clk_i); #1;
        chk("to_next_rdata", 64'(r_rdata_o), 64'h0BADF00D);
        chk("to_next_adr", 64'(wb_adr_o), 64'h6004);

        gt0 = gnt_total; rv0 = rv_total;
        s_rdata = 32'h11112222; add_i = 32'h7000; req_i = 1'b1;
        wait_gnt();
        wait_rv();
        @(negedge clk_i);
        chk("b2b_gnt2", 64'(gnt_o), 64'd1);
        @(posedge clk_i); #1 req_i = 1'b0;
        wait_rv();
        @(posedge clk_i); #1;
        chk("b2b_gnt_count", 64'(gnt_total - gt0), 64'd2);
        chk("b2b_rv_count", 64'(rv_total - rv0), 64'd2);

        s_mode = 0; add_i = 32'h8000; req_i = 1'b1;
        wait_gnt();
        @(posedge clk_i); #1 req_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rst_pre_cyc", 64'(wb_cyc_o), 64'd1);
        rv0 = rv_total;
        rst_i = 1'b1;
        #1;
        chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
        chk("rst_rv", 64'(r_valid_o), 64'd0);
        chk("rst_adr", 64'(wb_adr_o), 64'd0);
        chk("rst_rdata", 64'(r_rdata_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1 chk("rst_no_rv", 64'(rv_total - rv0), 64'd0);

        s_rdata = 32'h12345678;
        txn(1'b0, 32'h9004, 32'h0, 4'hF, 1, 1);
        chk("post_rst_rdata", 64'(r_rdata_o), 64'h12345678);
        chk("post_rst_latency", 64'(last_lat), 64'd2);
        chk("rv_total", 64'(rv_total), 64'd8);

        repeat (2) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got expired expected finished");
        $fatal(1);
    end

endmodule

// File: doc/dm_sba_wb_responder.md
Name: dm_sba_wb_responder

Overview:
- Responder for the debug module's system-bus-access master port (req/gnt/r_valid protocol).
- Accepts one transaction at a time and replays it as a classic single-beat Wishbone master cycle onto the SoC bus.
- Returns exactly one r_valid per granted request, with read data or an error flag.
- Sits between the debug module's master port and the servant Wishbone interconnect, so the debugger can reach system memory.

Parameters:
- AddrWidth, 32, width of add_i and wb_adr_o.
- DataWidth, 32, width of the data buses; byte enables are DataWidth/8.
- TimeoutCycles, 255, maximum cycles to wait for wb_ack_i/wb_err_i; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  1  request from the DM master; held until granted
- add_i  in  AddrWidth  byte address
- we_i  in  1  1 = write, 0 = read
- wdata_i  in  DataWidth  write data
- be_i  in  DataWidth/8  byte enables
- gnt_o  out  1  grant; request accepted this cycle
- r_valid_o  out  1  one-cycle completion pulse; issued for reads and writes
- r_rdata_o  out  DataWidth  read data, qualified by r_valid_o
- r_err_o  out  1  bus error or timeout, qualified by r_valid_o
- wb_adr_o  out  AddrWidth  Wishbone address, word aligned
- wb_dat_o  out  DataWidth  Wishbone write data
- wb_sel_o  out  DataWidth/8  Wishbone byte select
- wb_we_o  out  1  Wishbone write enable
- wb_cyc_o  out  1  Wishbone cycle; wb_stb is the same signal
- wb_dat_i  in  DataWidth  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE; all outputs 0; timeout counter 0; captured command registers 0.
- States: IDLE, BUS, RESP.
- IDLE:
  - gnt_o = req_i, combinational, asserted only in IDLE.
  - On req_i: capture the command registers; go to BUS.
  - Captured fields: wb_adr_o = {add_i[AddrWidth-1:2], 2'b00}; wb_sel_o = be_i; wb_dat_o = wdata_i; wb_we_o = we_i.
- BUS:
  - wb_cyc_o = 1; counter increments each cycle.
  - wb_ack_i: capture rdata (wb_dat_i for reads, 0 for writes); r_err_o = 0; go to RESP.
  - wb_err_i (without ack): rdata = 0; err = 1; go to RESP.
  - Counter == TimeoutCycles-1 with no ack/err (TimeoutCycles != 0): rdata = 0; err = 1; go to RESP.
  - Same-cycle priority: ack > err > timeout.
  - wb_cyc_o deasserts on the clock edge leaving BUS; address, data, sel and we are held stable throughout BUS.
- RESP:
  - r_valid_o = 1 for exactly one cycle; gnt_o = 0; return to IDLE; counter cleared.
  - r_rdata_o and r_err_o hold their values until the next response.
- Latency:
  - Grant at cycle T; wb_cyc_o high at T+1.
  - Ack at cycle T+k (k ≥ 1) gives r_valid_o at T+k+1.
  - Minimum grant-to-r_valid latency is 2 cycles.
  - Next grant possible at the cycle after r_valid_o.
- req_i seen outside IDLE is ignored (not granted) until IDLE. The DM master holds req_i, so nothing is lost.
- Reset mid-transaction: wb_cyc_o drops asynchronously and no r_valid_o is produced. The DM is reset on the same domain, so no orphaned response is expected.
- wb_ack_i or wb_err_i outside BUS is ignored.
- add_i[1:0] has no effect on wb_adr_o; byte lanes are selected only by be_i.

Decomposition:
- Package dm_sba_wb_pkg: state enum (IDLE, BUS, RESP, 2-bit encoding).
- Package dm_sba_wb_pkg also holds the counter width constant, $clog2(TimeoutCycles+1), minimum 1.
- No sub-module; one FSM process plus capture registers. The counter is inline.

Test Plan:
- Read, ack 1 cycle after cyc: req_i=1, we_i=0, add_i=0x2004, be=0xF, wb_dat_i=0xDEADBEEF.
  - Expect gnt_o at T; wb_cyc_o at T+1 with wb_adr_o=0x2004.
  - Expect r_valid_o at T+2 with r_rdata_o=0xDEADBEEF, r_err_o=0.
- Write with 3-cycle wait: add_i=0x3001, wdata=0x000000AA, be=0x2.
  - Expect wb_adr_o=0x3000, wb_sel_o=0x2, wb_we_o=1, wb_cyc_o high for 4 cycles.
  - Expect one r_valid_o with r_rdata_o=0, r_err_o=0.
- Bus error: wb_err_i asserted on the 2nd BUS cycle of a read.
  - Expect r_valid_o with r_err_o=1, r_rdata_o=0; wb_cyc_o low the following cycle.
- Timeout: TimeoutCycles=8, slave never acks.
  - Expect wb_cyc_o high exactly 8 cycles, then r_valid_o with r_err_o=1; next req_i granted the cycle after.
- Back-to-back: req_i held continuously across two reads.
  - Expect no gnt_o during BUS/RESP; second gnt_o the cycle after the first r_valid_o; exactly two r_valid_o pulses.
- Reset mid-BUS: assert rst_i while wb_cyc_o=1.
  - Expect wb_cyc_o=0 in the same cycle, no r_valid_o, all outputs 0.
  - After release, a read completes normally.
